// File: rtl/ascon_pack.sv
// Shared Ascon types and constants used by the datapath and its input FIFOs.
package ascon_pack;
  typedef logic [63:0] u64_t;
  typedef logic [31:0] u32_t;

  localparam int FIFO_AW_DEFAULT = 4;
endpackage

// File: rtl/ascon_fifo_if.sv
// Bus/core-facing signals of ascon_fifo: half-block writes in, 64-bit blocks out.
interface ascon_fifo_if #(
  parameter int FIFO_AW = ascon_pack::FIFO_AW_DEFAULT
);
  import ascon_pack::*;

  logic             wr_en_i;
  u32_t             wdata_i;
  logic             pop_i;
  logic             flush_i;
  u64_t             data_o;
  logic             empty_o;
  logic             full_o;
  logic             half_o;
  logic [FIFO_AW:0] level_o;

  modport master (
    output wr_en_i, wdata_i, pop_i, flush_i,
    input  data_o, empty_o, full_o, half_o, level_o
  );

  modport slave (
    input  wr_en_i, wdata_i, pop_i, flush_i,
    output data_o, empty_o, full_o, half_o, level_o
  );
endinterface

// File: rtl/ascon_fifo_mem.sv
// 2^AW x 64 register array: synchronous write, asynchronous read, no reset.
module fifo_mem
  import ascon_pack::*;
#(
  parameter int AW = FIFO_AW_DEFAULT
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  u64_t          i_wdata,
  input  logic [AW-1:0] i_raddr,
  output u64_t          o_rdata
);
  u64_t r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ascon_fifo.sv
// Word-packing FWFT FIFO: two 32-bit writes form one big-endian 64-bit block.
// Optional sticky overflow/underflow flags with `ASCON_FIFO_ERR_EN.
module ascon_fifo
  import ascon_pack::*;
#(
  parameter int FIFO_AW = FIFO_AW_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  ascon_fifo_if.slave  bus
`ifdef ASCON_FIFO_ERR_EN
  ,
  output logic         overflow_o,
  output logic         underflow_o,
  input  logic         clr_err_i
`endif
);
  logic [FIFO_AW:0] r_wr_ptr, r_rd_ptr;
  u32_t             r_stage;
  logic             r_half;

  logic w_empty, w_full, w_second, w_push, w_pop, w_we;
  u64_t w_rdata;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                    (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
  assign w_second = bus.wr_en_i & r_half;
  // A completing write into a full FIFO only lands if a pop frees a slot.
  assign w_push   = w_second & (~w_full | bus.pop_i);
  assign w_pop    = bus.pop_i & ~w_empty;
  assign w_we     = w_push & ~bus.flush_i & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_stage  <= '0;
      r_half   <= 1'b0;
    end else if (bus.flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_stage  <= '0;
      r_half   <= 1'b0;
    end else begin
      if (bus.wr_en_i && !r_half) begin
        r_stage <= bus.wdata_i;
        r_half  <= 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_half   <= 1'b0;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  fifo_mem #(.AW(FIFO_AW)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr[FIFO_AW-1:0]),
    .i_wdata ({r_stage, bus.wdata_i}),
    .i_raddr (r_rd_ptr[FIFO_AW-1:0]),
    .o_rdata (w_rdata)
  );

  assign bus.data_o  = w_empty ? '0 : w_rdata;
  assign bus.empty_o = w_empty;
  assign bus.full_o  = w_full;
  assign bus.half_o  = r_half;
  assign bus.level_o = r_wr_ptr - r_rd_ptr;

`ifdef ASCON_FIFO_ERR_EN
  logic w_drop, w_under;
  assign w_drop  = w_second & w_full & ~bus.pop_i & ~bus.flush_i;
  assign w_under = bus.pop_i & w_empty & ~bus.flush_i;

  // Error events override a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (clr_err_i) begin
        overflow_o  <= 1'b0;
        underflow_o <= 1'b0;
      end
      if (w_drop)  overflow_o  <= 1'b1;
      if (w_under) underflow_o <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_ascon_fifo.sv
// Randomized + directed bench for ascon_fifo against a queue-based reference model.
module tb_ascon_fifo;
  import ascon_pack::*;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
`ifdef ASCON_FIFO_ERR_EN
  logic ovf, unf;
`endif

  ascon_fifo_if #(.FIFO_AW(AW)) bus ();

  ascon_fifo #(.FIFO_AW(AW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ASCON_FIFO_ERR_EN
    ,
    .overflow_o  (ovf),
    .underflow_o (unf),
    .clr_err_i   (clr)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model
  u64_t m_q[$];
  u32_t m_stage;
  bit   m_half, m_ovf, m_unf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit wr, input u32_t wd, input bit p, input bit f, input bit c);
    bit full, empty, ev_o, ev_u;
    ev_o = 0; ev_u = 0;
    if (r) begin
      m_q.delete(); m_stage = '0; m_half = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    if (f) begin
      m_q.delete(); m_stage = '0; m_half = 0;
    end else begin
      full  = (m_q.size() == DEPTH);
      empty = (m_q.size() == 0);
      if (p) begin
        if (empty) ev_u = 1;
        else void'(m_q.pop_front());
      end
      if (wr) begin
        if (!m_half) begin
          m_stage = wd; m_half = 1;
        end else if (full && !p) begin
          ev_o = 1;
        end else begin
          m_q.push_back({m_stage, wd}); m_half = 0;
        end
      end
    end
    if (c) begin m_ovf = 0; m_unf = 0; end
    if (ev_o) m_ovf = 1;
    if (ev_u) m_unf = 1;
  endtask

  task automatic compare_all();
    chk("empty", 64'(bus.empty_o), 64'(m_q.size() == 0));
    chk("full",  64'(bus.full_o),  64'(m_q.size() == DEPTH));
    chk("half",  64'(bus.half_o),  64'(m_half));
    chk("level", 64'(bus.level_o), 64'(m_q.size()));
    chk("data",  bus.data_o, (m_q.size() == 0) ? 64'h0 : m_q[0]);
`ifdef ASCON_FIFO_ERR_EN
    chk("ovf", 64'(ovf), 64'(m_ovf));
    chk("unf", 64'(unf), 64'(m_unf));
`endif
  endtask

  task automatic cyc(input bit r, input bit wr, input u32_t wd, input bit p, input bit f, input bit c);
    rst = r; bus.wr_en_i = wr; bus.wdata_i = wd; bus.pop_i = p; bus.flush_i = f; clr = c;
    @(posedge clk);
    model(r, wr, wd, p, f, c);
    #1;
    compare_all();
  endtask

  task automatic idle(); cyc(0, 0, '0, 0, 0, 0); endtask
  task automatic wr1(input u32_t d); cyc(0, 1, d, 0, 0, 0); endtask
  task automatic pop1(); cyc(0, 0, '0, 1, 0, 0); endtask

  initial begin
    bus.wr_en_i = 0; bus.wdata_i = '0; bus.pop_i = 0; bus.flush_i = 0;
    // Reset: garbage strobes must not matter
    cyc(1, 1, 32'hDEADBEEF, 1, 0, 0);
    cyc(1, 0, '0, 0, 0, 0);
    chk("rst_empty", 64'(bus.empty_o), 64'd1);
    chk("rst_level", 64'(bus.level_o), 64'd0);

    // Basic packing, big-endian order
    wr1(32'h01234567);
    chk("tp1_half", 64'(bus.half_o), 64'd1);
    wr1(32'h89ABCDEF);
    chk("tp1_data", bus.data_o, 64'h0123456789ABCDEF);
    chk("tp1_level", 64'(bus.level_o), 64'd1);
    pop1();
    chk("tp1_pop_data", bus.data_o, 64'h0);

    // Fill to full, drop a second half, then pop + complete
    for (int i = 0; i < DEPTH; i++) begin
      wr1($urandom); wr1($urandom);
    end
    chk("tp2_full", 64'(bus.full_o), 64'd1);
    chk("tp2_level", 64'(bus.level_o), 64'(DEPTH));
    wr1(32'hAAAA0001);
    wr1(32'hBBBB0002);
    chk("tp2_half_kept", 64'(bus.half_o), 64'd1);
    cyc(0, 1, 32'hCCCC0003, 1, 0, 0);
    chk("tp2_level_same", 64'(bus.level_o), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) pop1();
    chk("tp2_last_empty", 64'(bus.empty_o), 64'd1);

    // Pop on empty, then clear
    pop1();
    idle();
    cyc(0, 0, '0, 0, 0, 1);
    // Clear racing a fresh underflow: event wins
    pop1();
    cyc(0, 0, '0, 1, 0, 1);
    cyc(0, 0, '0, 0, 0, 1);

    // Random interleaved traffic with rare flush/clear
    for (int i = 0; i < 700; i++) begin
      bit w, p, f, c;
      w = ($urandom_range(0, 99) < 62);
      p = ($urandom_range(0, 99) < (i < 350 ? 22 : 48));
      f = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 29) == 0);
      cyc(0, w, $urandom, p, f, c);
    end

    // Flush beats a same-cycle write and pop, no error flags
    cyc(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin wr1($urandom); wr1($urandom); end
    wr1(32'h5A5A5A5A);
    cyc(0, 1, 32'h12345678, 1, 1, 0);
    chk("flush_empty", 64'(bus.empty_o), 64'd1);
    chk("flush_half", 64'(bus.half_o), 64'd0);
    chk("flush_level", 64'(bus.level_o), 64'd0);
    idle();

    // Reset mid-operation
    for (int i = 0; i < 5; i++) begin wr1($urandom); wr1($urandom); end
    wr1(32'h77777777);
    pop1(); pop1(); pop1(); pop1(); pop1(); pop1();
    cyc(0, 1, '0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin wr1($urandom); wr1($urandom); end
    wr1(32'h66666666);
    cyc(1, 1, 32'h11111111, 1, 0, 0);
    chk("mid_rst_half", 64'(bus.half_o), 64'd0);
    chk("mid_rst_empty", 64'(bus.empty_o), 64'd1);
    chk("mid_rst_data", bus.data_o, 64'h0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
